multwrap_bram_sequencer: RTL and testbench

Controller placed in front of top_multwrap_bram. It receives input-matrix words and then weight words from a single valid/ready stream. It packs each even/odd pair into one dual-port write cycle on the input BRAMs or weight BRAMs, pulses the datapath start, and waits for the datapath done with a watchdog. It replaces hand-driven BRAM filling and exposes busy/done/error status to the system.

---
 rtl/linear_proj_pkg.sv | 20 ++
 rtl/bram_pair_writer.sv | 86 ++++++++
 rtl/multwrap_bram_sequencer.sv | 169 ++++++++++++++++
 tb/tb_multwrap_bram_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/linear_proj_pkg.sv
// Shared types and constants for the linear-projection datapath and its BRAM sequencer.
package linear_proj_pkg;

    localparam int unsigned SEQ_TIMEOUT_CYCLES = 65535;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        KICK,
        WAIT_DONE,
        DONE,
        ERR
    } seq_state_t;

    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bram_pair_writer.sv
// Packs a stream of words into dual-port BRAM writes: even word held, odd word
// written together with it; an odd-length tail goes out on port A alone.
module bram_pair_writer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_WORDS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  beat,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  last_beat_c,
    output logic                  ena,
    output logic                  wea,
    output logic                  enb,
    output logic                  web,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] dinb,
    output logic                  last_written
);

    localparam int unsigned CW = $clog2(NUM_WORDS) + 1;

    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] hold;
    logic                  take;
    logic                  is_last;

    // Counter saturates at NUM_WORDS, so extra beats are never written.
    assign take        = beat && (cnt < CW'(NUM_WORDS));
    assign is_last     = (cnt == CW'(NUM_WORDS - 1));
    assign last_beat_c = take && is_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            hold         <= '0;
            ena          <= 1'b0;
            wea          <= 1'b0;
            enb          <= 1'b0;
            web          <= 1'b0;
            addra        <= '0;
            addrb        <= '0;
            dina         <= '0;
            dinb         <= '0;
            last_written <= 1'b0;
        end else begin
            ena <= 1'b0;
            wea <= 1'b0;
            enb <= 1'b0;
            web <= 1'b0;
            if (clear) begin
                cnt          <= '0;
                last_written <= 1'b0;
            end else if (take) begin
                cnt <= cnt + CW'(1);
                if (!cnt[0]) begin
                    hold <= data;
                    if (is_last) begin
                        ena          <= 1'b1;
                        wea          <= 1'b1;
                        addra        <= ADDR_WIDTH'(cnt);
                        dina         <= data;
                        last_written <= 1'b1;
                    end
                end else begin
                    ena   <= 1'b1;
                    wea   <= 1'b1;
                    enb   <= 1'b1;
                    web   <= 1'b1;
                    addra <= ADDR_WIDTH'(cnt - CW'(1));
                    dina  <= hold;
                    addrb <= ADDR_WIDTH'(cnt);
                    dinb  <= data;
                    if (is_last) begin
                        last_written <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/multwrap_bram_sequencer.sv
// Loads input and weight BRAMs from one stream, kicks the matmul datapath and
// watches for its completion with a watchdog.
module multwrap_bram_sequencer
    import linear_proj_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_A   = 64,
    parameter int unsigned DATA_WIDTH_B   = 128,
    parameter int unsigned ADDR_WIDTH_A   = 8,
    parameter int unsigned ADDR_WIDTH_B   = 8,
    parameter int unsigned NUM_A_WORDS    = 16,
    parameter int unsigned NUM_B_WORDS    = 32,
    parameter int unsigned TIMEOUT_CYCLES = SEQ_TIMEOUT_CYCLES
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            cmd_start,
    input  logic                                            s_valid,
    output logic                                            s_ready,
    input  logic [max_w(DATA_WIDTH_A, DATA_WIDTH_B)-1:0]    s_data,
    output logic                                            in_mat_ena,
    output logic                                            in_mat_wea,
    output logic                                            in_mat_enb,
    output logic                                            in_mat_web,
    output logic [ADDR_WIDTH_A-1:0]                         in_mat_wr_addra,
    output logic [ADDR_WIDTH_A-1:0]                         in_mat_wr_addrb,
    output logic [DATA_WIDTH_A-1:0]                         in_mat_dina,
    output logic [DATA_WIDTH_A-1:0]                         in_mat_dinb,
    output logic                                            w_mat_ena,
    output logic                                            w_mat_wea,
    output logic                                            w_mat_enb,
    output logic                                            w_mat_web,
    output logic [ADDR_WIDTH_B-1:0]                         w_mat_wr_addra,
    output logic [ADDR_WIDTH_B-1:0]                         w_mat_wr_addrb,
    output logic [DATA_WIDTH_B-1:0]                         w_mat_dina,
    output logic [DATA_WIDTH_B-1:0]                         w_mat_dinb,
    output logic                                            mm_start,
    input  logic                                            mm_done,
    output logic                                            busy,
    output logic                                            job_done,
    output logic                                            timeout_err
);

    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_t     state;
    logic [WDW-1:0] wd;
    logic           clear_c;
    logic           a_beat_c;
    logic           b_beat_c;
    logic           a_last_beat_c;
    logic           b_last_beat_c;
    logic           a_last_written;
    logic           b_last_written;

    assign clear_c  = (state == IDLE);
    assign a_beat_c = s_valid && s_ready && (state == LOAD_A);
    assign b_beat_c = s_valid && s_ready && (state == LOAD_B);

    bram_pair_writer #(
        .DATA_WIDTH (DATA_WIDTH_A),
        .ADDR_WIDTH (ADDR_WIDTH_A),
        .NUM_WORDS  (NUM_A_WORDS)
    ) u_writer_a (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear_c),
        .beat         (a_beat_c),
        .data         (s_data[DATA_WIDTH_A-1:0]),
        .last_beat_c  (a_last_beat_c),
        .ena          (in_mat_ena),
        .wea          (in_mat_wea),
        .enb          (in_mat_enb),
        .web          (in_mat_web),
        .addra        (in_mat_wr_addra),
        .addrb        (in_mat_wr_addrb),
        .dina         (in_mat_dina),
        .dinb         (in_mat_dinb),
        .last_written (a_last_written)
    );

    bram_pair_writer #(
        .DATA_WIDTH (DATA_WIDTH_B),
        .ADDR_WIDTH (ADDR_WIDTH_B),
        .NUM_WORDS  (NUM_B_WORDS)
    ) u_writer_b (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear_c),
        .beat         (b_beat_c),
        .data         (s_data[DATA_WIDTH_B-1:0]),
        .last_beat_c  (b_last_beat_c),
        .ena          (w_mat_ena),
        .wea          (w_mat_wea),
        .enb          (w_mat_enb),
        .web          (w_mat_web),
        .addra        (w_mat_wr_addra),
        .addrb        (w_mat_wr_addrb),
        .dina         (w_mat_dina),
        .dinb         (w_mat_dinb),
        .last_written (b_last_written)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            s_ready     <= 1'b0;
            mm_start    <= 1'b0;
            busy        <= 1'b0;
            job_done    <= 1'b0;
            timeout_err <= 1'b0;
            wd          <= '0;
        end else begin
            mm_start <= 1'b0;
            job_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        state       <= LOAD_A;
                        s_ready     <= 1'b1;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                    end
                end
                LOAD_A: begin
                    if (a_last_beat_c) begin
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (b_last_beat_c) begin
                        state   <= KICK;
                        s_ready <= 1'b0;
                    end
                end
                // The final weight write is on the BRAM port this cycle; start follows it.
                KICK: begin
                    if (a_last_written && b_last_written) begin
                        mm_start <= 1'b1;
                        wd       <= '0;
                        state    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (mm_done) begin
                        state    <= DONE;
                        job_done <= 1'b1;
                        busy     <= 1'b0;
                    end else if (wd == WDW'(TIMEOUT_CYCLES - 1)) begin
                        state       <= ERR;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        wd <= wd + WDW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multwrap_bram_sequencer.sv
// Scoreboard bench for multwrap_bram_sequencer: stimulus queues expected BRAM
// writes and status events; a negedge monitor pops and compares them.
module tb_multwrap_bram_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_start = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        in_mat_ena, in_mat_wea, in_mat_enb, in_mat_web;
    logic [7:0]  in_mat_wr_addra, in_mat_wr_addrb;
    logic [15:0] in_mat_dina, in_mat_dinb;
    logic        w_mat_ena, w_mat_wea, w_mat_enb, w_mat_web;
    logic [7:0]  w_mat_wr_addra, w_mat_wr_addrb;
    logic [31:0] w_mat_dina, w_mat_dinb;
    logic        mm_start;
    logic        mm_done = 1'b0;
    logic        busy, job_done, timeout_err;

    multwrap_bram_sequencer #(
        .DATA_WIDTH_A   (16),
        .DATA_WIDTH_B   (32),
        .ADDR_WIDTH_A   (8),
        .ADDR_WIDTH_B   (8),
        .NUM_A_WORDS    (5),
        .NUM_B_WORDS    (6),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_start       (cmd_start),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .in_mat_ena      (in_mat_ena),
        .in_mat_wea      (in_mat_wea),
        .in_mat_enb      (in_mat_enb),
        .in_mat_web      (in_mat_web),
        .in_mat_wr_addra (in_mat_wr_addra),
        .in_mat_wr_addrb (in_mat_wr_addrb),
        .in_mat_dina     (in_mat_dina),
        .in_mat_dinb     (in_mat_dinb),
        .w_mat_ena       (w_mat_ena),
        .w_mat_wea       (w_mat_wea),
        .w_mat_enb       (w_mat_enb),
        .w_mat_web       (w_mat_web),
        .w_mat_wr_addra  (w_mat_wr_addra),
        .w_mat_wr_addrb  (w_mat_wr_addrb),
        .w_mat_dina      (w_mat_dina),
        .w_mat_dinb      (w_mat_dinb),
        .mm_start        (mm_start),
        .mm_done         (mm_done),
        .busy            (busy),
        .job_done        (job_done),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  aa;
        logic [31:0] da;
        logic        eb;
        logic [7:0]  ab;
        logic [31:0] db;
    } wr_t;

    typedef enum int {EV_START, EV_DONE, EV_TO} ev_t;

    wr_t exp_in[$];
    wr_t exp_w[$];
    ev_t exp_ev[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic beat_q = 1'b0;

    // Upper half of each A word is junk that must not reach the input BRAM.
    logic [31:0] a_words[5] = '{32'hDEAD1100, 32'hBEEF2211, 32'hCAFE3322, 32'hF00D4433, 32'h12345544};
    logic [31:0] b_words[6] = '{32'hB0000000, 32'hB1111111, 32'hB2222222,
                                32'hB3333333, 32'hB4444444, 32'hB5555555};

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) beat_q <= s_valid && s_ready;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic wr_t mk(input logic [7:0] aa, input logic [31:0] da, input logic eb,
                               input logic [7:0] ab, input logic [31:0] db);
        mk = {aa, da, eb, ab, db};
    endfunction

    task automatic push_a();
        exp_in.push_back(mk(8'd0, 32'h1100, 1'b1, 8'd1, 32'h2211));
        exp_in.push_back(mk(8'd2, 32'h3322, 1'b1, 8'd3, 32'h4433));
        exp_in.push_back(mk(8'd4, 32'h5544, 1'b0, 8'd0, 32'h0));
    endtask

    task automatic push_b(input bit full);
        exp_w.push_back(mk(8'd0, 32'hB0000000, 1'b1, 8'd1, 32'hB1111111));
        if (full) begin
            exp_w.push_back(mk(8'd2, 32'hB2222222, 1'b1, 8'd3, 32'hB3333333));
            exp_w.push_back(mk(8'd4, 32'hB4444444, 1'b1, 8'd5, 32'hB5555555));
        end
    endtask

    int last_w_cyc = -100;
    int start_cyc  = -100;
    int mdone_cyc  = -100;
    logic prev_to = 1'b0;
    logic prev_md = 1'b0;

    // Monitor: every write and status event must match the head of its queue.
    always @(negedge clk) begin
        wr_t e;
        if (mm_done && !prev_md) mdone_cyc = cyc;
        prev_md = mm_done;

        if (in_mat_ena || in_mat_enb) begin
            chk("in_write_after_beat", beat_q, 1);
            if (exp_in.size() == 0) chk("in_write_unexpected", 1, 0);
            else begin
                e = exp_in.pop_front();
                chk("in_port_a", {in_mat_ena, in_mat_wea, in_mat_wr_addra, 16'h0, in_mat_dina},
                    {2'b11, e.aa, e.da});
                chk("in_port_b_en", {in_mat_enb, in_mat_web}, {e.eb, e.eb});
                if (e.eb) chk("in_port_b", {in_mat_wr_addrb, 16'h0, in_mat_dinb}, {e.ab, e.db});
            end
        end

        if (w_mat_ena || w_mat_enb) begin
            chk("w_write_after_beat", beat_q, 1);
            if (exp_w.size() == 0) chk("w_write_unexpected", 1, 0);
            else begin
                e = exp_w.pop_front();
                chk("w_port_a", {w_mat_ena, w_mat_wea, w_mat_wr_addra, w_mat_dina},
                    {2'b11, e.aa, e.da});
                chk("w_port_b_en", {w_mat_enb, w_mat_web}, {e.eb, e.eb});
                if (e.eb) chk("w_port_b", {w_mat_wr_addrb, w_mat_dinb}, {e.ab, e.db});
            end
            last_w_cyc = cyc;
        end

        if (mm_start) begin
            if (exp_ev.size() == 0 || exp_ev[0] != EV_START) chk("mm_start_unexpected", mm_start, 0);
            else begin
                void'(exp_ev.pop_front());
                chk("mm_start_after_last_write", cyc, last_w_cyc + 1);
                chk("busy_at_mm_start", busy, 1);
            end
            start_cyc = cyc;
        end

        if (job_done) begin
            if (exp_ev.size() == 0 || exp_ev[0] != EV_DONE) chk("job_done_unexpected", job_done, 0);
            else begin
                void'(exp_ev.pop_front());
                chk("job_done_latency", cyc, mdone_cyc + 1);
                chk("busy_low_at_job_done", busy, 0);
                chk("no_timeout_at_job_done", timeout_err, 0);
            end
        end

        if (timeout_err && !prev_to) begin
            if (exp_ev.size() == 0 || exp_ev[0] != EV_TO) chk("timeout_unexpected", timeout_err, 0);
            else begin
                void'(exp_ev.pop_front());
                chk("timeout_latency", cyc, start_cyc + 20);
                chk("busy_low_at_timeout", busy, 0);
            end
        end
        prev_to = timeout_err;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input bit bub);
        int n = 0;
        if (bub && $urandom_range(0, 1) == 1) begin
            s_valid = 1'b0;
            tick();
        end
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 20) begin
            tick();
            n++;
        end
        if (!s_ready) chk("s_ready_timeout", s_ready, 1);
        else tick();
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_ctrl"}, {s_ready, in_mat_ena, in_mat_wea, in_mat_enb, in_mat_web,
                              w_mat_ena, w_mat_wea, w_mat_enb, w_mat_web,
                              mm_start, busy, job_done, timeout_err}, 0);
        chk({name, "_addr_data"}, {in_mat_wr_addra, in_mat_wr_addrb, in_mat_dina, in_mat_dinb,
                                   w_mat_wr_addra, w_mat_wr_addrb, w_mat_dina, w_mat_dinb}, 0);
    endtask

    // done_delay < 0 means mm_done never arrives and the watchdog must fire.
    task automatic run_job(input bit bub, input bit hold_cmd, input int done_delay);
        int n = 0;
        push_a();
        push_b(1'b1);
        exp_ev.push_back(EV_START);
        cmd_start = 1'b1;
        tick();
        if (!hold_cmd) cmd_start = 1'b0;
        chk("busy_on_accept", busy, 1);
        chk("timeout_err_cleared_on_accept", timeout_err, 0);
        foreach (a_words[i]) send(a_words[i], bub);
        cmd_start = 1'b0;
        foreach (b_words[i]) send(b_words[i], bub);
        s_valid = 1'b0;
        while (!mm_start && n < 20) begin
            tick();
            n++;
        end
        chk("mm_start_seen", mm_start, 1);
        if (done_delay >= 0) begin
            repeat (done_delay) tick();
            mm_done = 1'b1;
            exp_ev.push_back(EV_DONE);
            tick();
            mm_done = 1'b0;
            repeat (3) tick();
            chk("idle_after_done", {busy, job_done, timeout_err}, 0);
        end else begin
            exp_ev.push_back(EV_TO);
            repeat (25) tick();
            chk("timeout_sticky", {timeout_err, busy}, 2'b10);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        repeat (2) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        run_job(1'b0, 1'b0, 10);
        run_job(1'b1, 1'b0, 10);
        run_job(1'b0, 1'b0, -1);
        // Held cmd_start plus mm_done on the very cycle the watchdog expires.
        run_job(1'b0, 1'b1, 19);

        // Abort during weight word 3: only the first weight pair was written.
        push_a();
        push_b(1'b0);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        foreach (a_words[i]) send(a_words[i], 1'b0);
        for (int i = 0; i < 3; i++) send(b_words[i], 1'b0);
        s_data  = b_words[3];
        s_valid = 1'b1;
        rst     = 1'b1;
        tick();
        rst     = 1'b0;
        s_valid = 1'b0;
        check_reset_outputs("mid_job_reset");
        repeat (30) tick();
        chk("idle_after_abort", {busy, s_ready}, 0);

        run_job(1'b0, 1'b0, 3);

        repeat (5) tick();
        chk("in_writes_drained", exp_in.size(), 0);
        chk("w_writes_drained", exp_w.size(), 0);
        chk("events_drained", exp_ev.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
